// File: rtl/otter_wb_queue.sv
// otter_wb_queue: in-order writeback FIFO between the result producers
// (ALU completion, L1 load return) and the single register-file write port.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   alu_valid/rd/data/ready ALU result handshake (lower priority)
//   mem_valid/rd/data/ready load result handshake (fixed priority)
//   wb_stall                write port unavailable; head is held
//   WriteReg/Data, RegWrite register-file write port driven from the head entry
//   Read1/Read2             register numbers being read from the register file
//   fwdN_hit/fwdN_data      youngest queued write matching ReadN
//   count, empty, full      occupancy
module otter_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [31:0]                mem_data,
  output logic                       mem_ready,
  input  logic                       wb_stall,
  output logic [4:0]                 WriteReg,
  output logic [31:0]                WriteData,
  output logic                       RegWrite,
  input  logic [4:0]                 Read1,
  input  logic [4:0]                 Read2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [31:0]                fwd1_data,
  output logic [31:0]                fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count_q;

  logic          enq_fire;
  logic          push;
  logic          pop;
  logic [4:0]    enq_rd;
  logic [31:0]   enq_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Readiness depends only on the registered full flag, so a pop on the
  // coming edge never opens a slot in the same cycle.
  assign mem_ready = !reset && !full;
  assign alu_ready = !reset && !full && !mem_valid;

  assign enq_rd   = mem_valid ? mem_rd   : alu_rd;
  assign enq_data = mem_valid ? mem_data : alu_data;
  assign enq_fire = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  // x0 results finish their handshake but never occupy a slot.
  assign push     = enq_fire && (enq_rd != '0);
  assign pop      = !reset && !empty && !wb_stall;

  assign RegWrite  = pop;
  assign WriteReg  = empty ? '0 : rd_q[head];
  assign WriteData = empty ? '0 : data_q[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      rd_q[tail]   <= enq_rd;
      data_q[tail] <= enq_data;
    end
  end

  // Walk oldest to youngest so a later match overrides an earlier one,
  // leaving the entry nearest the tail as the forwarded value.
  always_comb begin
    logic [AW-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count_q) begin
        if (Read1 != '0 && rd_q[idx] == Read1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if (Read2 != '0 && rd_q[idx] == Read2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_wb_queue.sv
module tb_otter_wb_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, wb_stall;
  logic [4:0]  alu_rd, mem_rd, Read1, Read2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  otter_wb_queue #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        stall;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_mr;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    alu_valid = v.av;   alu_rd = v.ard; alu_data = v.adat;
    mem_valid = v.mv;   mem_rd = v.mrd; mem_data = v.mdat;
    wb_stall  = v.stall;
    Read1     = v.r1;   Read2  = v.r2;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d alu_ready", n), {31'd0, alu_ready}, {31'd0, v.e_ar});
    chk($sformatf("v%0d mem_ready", n), {31'd0, mem_ready}, {31'd0, v.e_mr});
    chk($sformatf("v%0d RegWrite", n),  {31'd0, RegWrite},  {31'd0, v.e_rw});
    chk($sformatf("v%0d WriteReg", n),  {27'd0, WriteReg},  {27'd0, v.e_wr});
    chk($sformatf("v%0d WriteData", n), WriteData,          v.e_wd);
    chk($sformatf("v%0d fwd1_hit", n),  {31'd0, fwd1_hit},  {31'd0, v.e_h1});
    chk($sformatf("v%0d fwd1_data", n), fwd1_data,          v.e_d1);
    chk($sformatf("v%0d fwd2_hit", n),  {31'd0, fwd2_hit},  {31'd0, v.e_h2});
    chk($sformatf("v%0d fwd2_data", n), fwd2_data,          v.e_d2);
    chk($sformatf("v%0d count", n),     {29'd0, count},     {29'd0, v.e_cnt});
    chk($sformatf("v%0d empty", n),     {31'd0, empty},     {31'd0, (v.e_cnt == 3'd0)});
    chk($sformatf("v%0d full", n),      {31'd0, full},      {31'd0, (v.e_cnt == 3'd4)});
  endtask

  initial begin
    //          rst av ard adat          mv mrd mdat   st r1 r2   ar mr rw wr wd            h1 d1            h2 d2     cnt
    // reset state
    vecs[0]  = '{1, 0, 0, 0,             0, 0, 0,      0, 0, 0,   0, 0, 0, 0, 0,            0, 0,            0, 0,     0};
    // single write, committed one cycle later, forwarded while queued
    vecs[1]  = '{0, 1, 5, 32'hDEADBEEF,  0, 0, 0,      0, 5, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[2]  = '{0, 0, 0, 0,             0, 0, 0,      0, 5, 0,   1, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,     1};
    vecs[3]  = '{0, 0, 0, 0,             0, 0, 0,      0, 5, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    // mem priority over alu
    vecs[4]  = '{0, 1, 4, 32'h22,        1, 3, 32'h11, 0, 0, 0,   0, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[5]  = '{0, 1, 4, 32'h22,        0, 0, 0,      0, 0, 0,   1, 1, 1, 3, 32'h11,       0, 0,            0, 0,     1};
    vecs[6]  = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 1, 4, 32'h22,       0, 0,            0, 0,     1};
    vecs[7]  = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    // x0 discard
    vecs[8]  = '{0, 1, 0, 32'hFFFFFFFF,  0, 0, 0,      0, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[9]  = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    // youngest forwarding under stall, Read=0 never hits
    vecs[10] = '{0, 1, 7, 32'h1,         0, 0, 0,      1, 0, 7,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[11] = '{0, 1, 7, 32'h2,         0, 0, 0,      1, 0, 7,   1, 1, 0, 7, 32'h1,        0, 0,            1, 32'h1, 1};
    vecs[12] = '{0, 0, 0, 0,             0, 0, 0,      1, 0, 7,   1, 1, 0, 7, 32'h1,        0, 0,            1, 32'h2, 2};
    vecs[13] = '{0, 0, 0, 0,             0, 0, 0,      1, 7, 0,   1, 1, 0, 7, 32'h1,        1, 32'h2,        0, 0,     2};
    vecs[14] = '{0, 0, 0, 0,             0, 0, 0,      0, 7, 0,   1, 1, 1, 7, 32'h1,        1, 32'h2,        0, 0,     2};
    vecs[15] = '{0, 0, 0, 0,             0, 0, 0,      0, 7, 0,   1, 1, 1, 7, 32'h2,        1, 32'h2,        0, 0,     1};
    vecs[16] = '{0, 0, 0, 0,             0, 0, 0,      0, 7, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    // fill under stall, held-off fifth result, drain with pointer wrap
    vecs[17] = '{0, 1, 1, 32'h101,       0, 0, 0,      1, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[18] = '{0, 1, 2, 32'h102,       0, 0, 0,      1, 0, 0,   1, 1, 0, 1, 32'h101,      0, 0,            0, 0,     1};
    vecs[19] = '{0, 1, 3, 32'h103,       0, 0, 0,      1, 0, 0,   1, 1, 0, 1, 32'h101,      0, 0,            0, 0,     2};
    vecs[20] = '{0, 1, 4, 32'h104,       0, 0, 0,      1, 0, 0,   1, 1, 0, 1, 32'h101,      0, 0,            0, 0,     3};
    vecs[21] = '{0, 1, 5, 32'h105,       0, 0, 0,      1, 4, 0,   0, 0, 0, 1, 32'h101,      1, 32'h104,      0, 0,     4};
    vecs[22] = '{0, 1, 5, 32'h105,       0, 0, 0,      0, 0, 0,   0, 0, 1, 1, 32'h101,      0, 0,            0, 0,     4};
    vecs[23] = '{0, 1, 5, 32'h105,       0, 0, 0,      0, 0, 0,   1, 1, 1, 2, 32'h102,      0, 0,            0, 0,     3};
    vecs[24] = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 1, 3, 32'h103,      0, 0,            0, 0,     3};
    vecs[25] = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 1, 4, 32'h104,      0, 0,            0, 0,     2};
    vecs[26] = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 5,   1, 1, 1, 5, 32'h105,      0, 0,            1, 32'h105, 1};
    vecs[27] = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    // reset mid-operation drops three queued entries unwritten
    vecs[28] = '{0, 1, 10, 32'hA,        0, 0, 0,      1, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[29] = '{0, 1, 11, 32'hB,        0, 0, 0,      1, 0, 0,   1, 1, 0, 10, 32'hA,       0, 0,            0, 0,     1};
    vecs[30] = '{0, 1, 12, 32'hC,        0, 0, 0,      1, 11, 0,  1, 1, 0, 10, 32'hA,       1, 32'hB,        0, 0,     2};
    vecs[31] = '{1, 0, 0, 0,             0, 0, 0,      0, 0, 0,   0, 0, 0, 10, 32'hA,       0, 0,            0, 0,     3};
    vecs[32] = '{0, 0, 0, 0,             0, 0, 0,      0, 11, 0,  1, 1, 0, 0, 0,            0, 0,            0, 0,     0};
    vecs[33] = '{0, 0, 0, 0,             0, 0, 0,      0, 0, 0,   1, 1, 0, 0, 0,            0, 0,            0, 0,     0};

    drive(vecs[0]);
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
      @(posedge clock);
      #1;
    end

    // Back-to-back load results with no stall: one commit per cycle,
    // occupancy never exceeds one.
    for (int k = 0; k < 6; k++) begin
      vec_t v;
      v = vecs[33];
      v.mv = 1'b1; v.mrd = 5'(20 + k); v.mdat = 32'h500 + 32'(k);
      drive(v);
      #1;
      chk($sformatf("tp%0d mem_ready", k), {31'd0, mem_ready}, 32'd1);
      chk($sformatf("tp%0d count", k), {29'd0, count}, (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("tp%0d RegWrite", k), {31'd0, RegWrite}, (k == 0) ? 32'd0 : 32'd1);
      if (k != 0) begin
        chk($sformatf("tp%0d WriteReg", k), {27'd0, WriteReg}, 32'(19 + k));
        chk($sformatf("tp%0d WriteData", k), WriteData, 32'h500 + 32'(k - 1));
      end
      @(posedge clock);
      #1;
    end
    drive(vecs[33]);
    #1;
    chk("tp_last WriteReg", {27'd0, WriteReg}, 32'd25);
    chk("tp_last WriteData", WriteData, 32'h505);

    begin
      int waited;
      waited = 0;
      while (!empty && waited < 8) begin
        @(posedge clock);
        #1;
        waited++;
      end
      chk("drain_to_empty", {31'd0, empty}, 32'd1);
      chk("drain_cycles", 32'(waited), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_wb_queue.md
# otter_wb_queue

Writeback queue for the multicycle OTTER core. It sits between the result producers (ALU completion and L1-cache load return) and the single write port of the register file. It accepts at most one result per cycle over valid/ready handshakes and buffers results in a small in-order FIFO. It drains one entry per cycle onto the register-file write port and provides a forwarding lookup so the two register-file read ports never return a value older than a queued write.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; clears queue
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid  in  1  load result offered
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- mem_ready  out  1  load result accepted this cycle
- wb_stall  in  1  write port unavailable this cycle; no drain
- WriteReg  out  5  register-file write address (head entry)
- WriteData  out  32  register-file write data (head entry)
- RegWrite  out  1  register-file write enable
- Read1, Read2  in  5  register numbers being read from the register file
- fwd1_hit, fwd2_hit  out  1  queued write pending for Read1 / Read2
- fwd1_data, fwd2_data  out  32  youngest pending data for Read1 / Read2
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Storage: DEPTH entries of {rd[4:0], data[31:0]}. Head and tail pointers wrap modulo DEPTH. count is a separate register.
- Arbitration: mem has fixed priority.
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
  - At most one enqueue per cycle.
- Enqueue occurs on a clock edge when the selected source has valid && ready.
- An entry with rd==0 completes its handshake but is discarded. Nothing is written and count is unchanged.
- Drain: RegWrite = !empty && !wb_stall. WriteReg/WriteData present the head entry combinationally. The head pops on the same edge the register file writes.
- When empty, WriteReg and WriteData are 0.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- ready is derived from the registered full flag only. There is no same-cycle pass-through when full, even if a pop occurs.
- Forwarding, per read port:
  - hit = Read!=0 and some valid entry has a matching rd.
  - data = data of the youngest matching entry (nearest tail).
  - The head entry being written this cycle still counts as a hit.
  - When there is no hit, data = 0.
- The lookup is purely combinational from stored state. Same-cycle incoming results are not forwarded.
- Reset: head=tail=count=0, empty=1, full=0, RegWrite=0, all fwd hits 0. Storage contents are don't-care.
  - Reset mid-operation discards all queued entries without writing them.
  - ready outputs are 0 while reset is asserted.

## Timing
- Enqueue at edge N → entry visible on the write port and to forwarding during cycle N+1. The register file commits it at edge N+1 if the entry is at the head and wb_stall=0.
- Minimum enqueue-to-commit latency is 1 cycle. Worst case is DEPTH plus the number of stall cycles.
- Sustained throughput is 1 result per cycle when wb_stall=0.
- Full boundary: with count==DEPTH, both readys are low for that whole cycle, even if a pop happens at the next edge.
- Empty boundary: with count==0, RegWrite=0 regardless of wb_stall.
- Pointer wrap: entries written at index DEPTH-1 then 0 must drain in FIFO order.
- A held-off source must keep its valid/rd/data stable until ready.

## Test plan
- Single write: alu_valid with rd=5, data=0xDEADBEEF at edge 0 → cycle 1 shows RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF, fwd1_hit=1 when Read1=5; cycle 2 shows empty=1, RegWrite=0.
- Priority: mem(rd=3, 0x11) and alu(rd=4, 0x22) both valid in the same cycle → mem_ready=1, alu_ready=0. The ALU entry is accepted the next cycle, and commit order is x3 then x4.
- Fill/stall: wb_stall=1 with 4 ALU results for rd=1..4 → full=1, count=4, alu_ready=0 on the 5th. Releasing the stall drains 1..4 on consecutive cycles, and wrap is exercised by refilling.
- Forward youngest: queue rd=7/0x1 then rd=7/0x2 under stall with Read2=7 → fwd2_hit=1, fwd2_data=0x2. Read2=0 gives hit=0.
- x0 discard: alu rd=0, data=0xFFFFFFFF → alu_ready=1, count stays 0, RegWrite never asserts.
- Reset mid-operation: 3 entries queued under stall, then reset for 1 cycle → count=0, empty=1, RegWrite=0, no writes issued after reset deasserts.
